// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the memory-mapped UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Register offsets relative to BASE_WADDR
  localparam logic [9:0] REG_TXDATA  = 10'd0;
  localparam logic [9:0] REG_STATUS  = 10'd1;
  localparam logic [9:0] REG_BAUDDIV = 10'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - core data-port bundle (address, store/load strobes, select, read data)
interface uart_tx_mmio_if;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_w;
  logic        d_r;
  logic        sel;
  logic [31:0] rdata;

  modport master (output daddr, ddata_w, d_w, d_r, input sel, rdata);
  modport slave  (input daddr, ddata_w, d_w, d_r, output sel, rdata);
endinterface

// File: rtl/uart_tx_mmio_fifo.sv
// rtl/uart_tx_mmio_fifo.sv - sync_fifo: single-clock FIFO; a pop on the same edge lets a push into a full FIFO
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - MMIO UART transmitter: TXDATA/STATUS/BAUDDIV, TX FIFO, 8N1 serialiser
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [9:0]  BASE_WADDR = 10'h3F0,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic          CLK,
  input  logic          RSTn,
  uart_tx_mmio_if.slave bus,
  output logic          tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [9:0]    offset;
  logic          sel, wr;
  logic [31:0]   status, rdata;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  tx_state_t     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          bit_done;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Wrapping subtraction makes the range check a single compare
  assign offset    = bus.daddr - BASE_WADDR;
  assign sel       = (offset < 10'd3);
  assign wr        = sel && bus.d_w;
  assign fifo_push = wr && (offset == REG_TXDATA);
  assign bus.sel   = sel;
  assign bus.rdata = rdata;
  assign tx        = tx_q;
  assign bit_done  = (cnt_q == 16'd0);

  always_comb begin
    status                        = '0;
    status[STAT_BUSY]             = (state_q != ST_IDLE);
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_OVF]              = ovf_q;
    status[STAT_CNT_LSB +: 4]     = 4'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (sel && bus.d_r) begin
      case (offset)
        REG_STATUS:  rdata = status;
        REG_BAUDDIV: rdata = {16'd0, baud_q};
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (wr && offset == REG_BAUDDIV)
      baud_d = (bus.ddata_w[15:0] == 16'd0) ? 16'd1 : bus.ddata_w[15:0];
    if (fifo_push && fifo_full && !fifo_pop)
      ovf_d = 1'b1;
    if (wr && offset == REG_STATUS)
      ovf_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_rdata;
`endif
          tx_d     = 1'b0;
          cnt_d    = baud_q - 16'd1;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = 3'd0;
          cnt_d   = baud_q - 16'd1;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_d = baud_q - 16'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          tx_d    = 1'b1;
          cnt_d   = baud_q - 16'd1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          // Back-to-back frames: next start bit follows the stop bit with no idle gap
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d    = ^fifo_rdata;
`endif
            tx_d     = 1'b0;
            cnt_d    = baud_q - 16'd1;
            state_d  = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      baud_q  <= DIV_RESET;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.ddata_w[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed bench with serial-line monitor and expected-byte scoreboard
module tb_uart_tx_mmio;

  localparam logic [9:0] BASE = 10'h3F0;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic tx;

  uart_tx_mmio_if bus ();

  uart_tx_mmio dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 CLK = ~CLK;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         mon_div = 4;
  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;
  time        prev_start = 0, last_start = 0, last_end = 0;
  logic       mon_par = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    @(negedge CLK);
    bus.daddr   = BASE + 10'(off);
    bus.ddata_w = d;
    bus.d_w     = 1'b1;
    @(posedge CLK);
    #1;
    bus.d_w = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write(2'd0, {24'd0, b});
  endtask

  task automatic set_div(input int d);
    bus_write(2'd2, 32'(d));
    mon_div = (d == 0) ? 1 : d;
  endtask

  task automatic rd(input logic [9:0] a, input logic r, output logic [31:0] d, output logic s);
    bus.daddr = a;
    bus.d_r   = r;
    #1;
    d = bus.rdata;
    s = bus.sel;
    bus.d_r = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic        s;
    rd(BASE + 10'(off), 1'b1, d, s);
    chk(tag, d, exp);
  endtask

  task automatic drain(input string tag, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !mon_busy) break;
    end
    chk({tag, "_drain"}, 32'(i < limit), 32'd1);
    @(posedge CLK);
    #1;
    read_chk({tag, "_idle"}, 2'd1, 32'h4);
  endtask

  task automatic get_bit(output logic v, output logic steady);
    v = tx;
    steady = 1'b1;
    repeat (mon_div - 1) begin
      @(negedge CLK);
      if (tx !== v) steady = 1'b0;
    end
  endtask

  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tx === lvl && n < 64) begin
      n++;
      @(negedge CLK);
    end
  endtask

  // Serial-line monitor: decodes each frame and retires it against the scoreboard
  always begin : monitor
    logic       v, st;
    logic [7:0] data;
    time        t0;
    @(negedge CLK);
    if (mon_en && RSTn && tx === 1'b0) begin
      mon_busy = 1'b1;
      t0 = $time;
      get_bit(v, st);
      chk("mon_start_steady", 32'(st), 32'd1);
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        get_bit(v, st);
        data[k] = v;
        chk("mon_data_steady", 32'(st), 32'd1);
      end
`ifdef UART_TX_PARITY_EN
      @(negedge CLK);
      get_bit(v, st);
      mon_par = v;
      chk("mon_parity", 32'(v), 32'(^data));
      chk("mon_parity_steady", 32'(st), 32'd1);
`endif
      @(negedge CLK);
      get_bit(v, st);
      chk("mon_stop", 32'(v), 32'd1);
      chk("mon_stop_steady", 32'(st), 32'd1);
      chk("sb_frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      prev_start = last_start;
      last_start = t0;
      last_end   = $time;
      mon_busy   = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        s;
    int          n;
    bus.daddr = '0; bus.ddata_w = '0; bus.d_w = 1'b0; bus.d_r = 1'b0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    read_chk("rst_status", 2'd1, 32'h4);
    read_chk("rst_baud", 2'd2, 32'd434);
    @(negedge CLK);
    RSTn = 1'b1;

    // 1: single byte, latency and bit pattern
    set_div(4);
    mon_en = 1'b1;
    send(8'hA5);
    chk("t1_tx_before", 32'(tx), 32'd1);
    @(posedge CLK);
    #1;
    chk("t1_tx_start", 32'(tx), 32'd0);
    read_chk("t1_busy", 2'd1, 32'h5);
    drain("t1", 300);

    // 2: fill FIFO, overflow, OVF clear
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    read_chk("t2_full", 2'd1, 32'h83);
    bus_write(2'd0, 32'hEE);
    read_chk("t2_ovf", 2'd1, 32'h8B);
    bus_write(2'd1, 32'h0);
    read_chk("t2_ovf_clr", 2'd1, 32'h83);
    drain("t2", 1200);

    // 3: back-to-back frames with no gap
    send(8'h00);
    send(8'hFF);
    drain("t3", 400);
    chk("t3_gap", 32'((last_start - prev_start) / 10), 32'(FRAME_BITS * 4));
    chk("t3_total", 32'((last_end - prev_start) / 10 + 1), 32'(2 * FRAME_BITS * 4));

    // 4: divisor change mid-bit, zero divisor
    mon_en = 1'b0;
    bus_write(2'd0, 32'h55);
    @(posedge CLK);
    bus_write(2'd2, 32'd8);
    @(negedge CLK);
    run_len(1'b0, n);
    chk("t4_start_rest", 32'(n), 32'd3);
    run_len(1'b1, n);
    chk("t4_bit0_len", 32'(n), 32'd8);
    run_len(1'b0, n);
    chk("t4_bit1_len", 32'(n), 32'd8);
    repeat (100) @(posedge CLK);
    #1;
    read_chk("t4_idle", 2'd1, 32'h4);
    read_chk("t4_baud", 2'd2, 32'd8);
    bus_write(2'd2, 32'd0);
    read_chk("t4_baud_zero", 2'd2, 32'd1);
    set_div(4);
    mon_en = 1'b1;

    // 5: status while transmitting, read decode
    send(8'h31);
    send(8'h32);
    send(8'h33);
    send(8'h34);
    read_chk("t5_status", 2'd1, 32'h31);
    rd(BASE + 10'd1, 1'b0, d, s);
    chk("t5_nord_rdata", d, 32'h0);
    chk("t5_nord_sel", 32'(s), 32'd1);
    rd(BASE + 10'd3, 1'b1, d, s);
    chk("t5_above_rdata", d, 32'h0);
    chk("t5_above_sel", 32'(s), 32'd0);
    rd(BASE - 10'd1, 1'b1, d, s);
    chk("t5_below_rdata", d, 32'h0);
    chk("t5_below_sel", 32'(s), 32'd0);
    rd(BASE, 1'b1, d, s);
    chk("t5_txdata_rdata", d, 32'h0);
    chk("t5_txdata_sel", 32'(s), 32'd1);
    rd(BASE + 10'd2, 1'b1, d, s);
    chk("t5_baud_rdata", d, 32'd4);
    drain("t5", 800);

    // 6: reset mid-frame
    mon_en = 1'b0;
    bus_write(2'd0, 32'h3C);
    bus_write(2'd0, 32'hC3);
    repeat (10) @(posedge CLK);
    #3;
    read_chk("t6_pre", 2'd1, 32'h11);
    RSTn = 1'b0;
    #1;
    chk("t6_tx", 32'(tx), 32'd1);
    read_chk("t6_status", 2'd1, 32'h4);
    read_chk("t6_baud", 2'd2, 32'd434);
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (20) @(posedge CLK);
    #1;
    chk("t6_tx_quiet", 32'(tx), 32'd1);
    read_chk("t6_status_after", 2'd1, 32'h4);
    set_div(4);
    mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    drain("t6p", 200);
    chk("t6p_parity_bit", 32'(mon_par), 32'd1);
    chk("t6p_frame_len", 32'((last_end - last_start) / 10 + 1), 32'd44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
